// File: rtl/vga_pkg.sv
// Shared VGA raster definitions: 800x600@60 timing, counter widths and a mode
// record that the draw stages and the bench can pass around.
package vga_pkg;

  localparam int COUNT_W = 11;
  localparam int FRAME_W = 16;

  localparam int VGA_H_ACTIVE = 800;
  localparam int VGA_H_FP     = 40;
  localparam int VGA_H_SYNC   = 128;
  localparam int VGA_H_BP     = 88;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 600;
  localparam int VGA_V_FP     = 1;
  localparam int VGA_V_SYNC   = 4;
  localparam int VGA_V_BP     = 23;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef struct packed {
    logic [COUNT_W-1:0] h_active;
    logic [COUNT_W-1:0] h_fp;
    logic [COUNT_W-1:0] h_sync;
    logic [COUNT_W-1:0] h_bp;
    logic [COUNT_W-1:0] v_active;
    logic [COUNT_W-1:0] v_fp;
    logic [COUNT_W-1:0] v_sync;
    logic [COUNT_W-1:0] v_bp;
  } vga_mode_t;

  localparam vga_mode_t MODE_800X600 = '{
    h_active: COUNT_W'(VGA_H_ACTIVE), h_fp: COUNT_W'(VGA_H_FP),
    h_sync:   COUNT_W'(VGA_H_SYNC),   h_bp: COUNT_W'(VGA_H_BP),
    v_active: COUNT_W'(VGA_V_ACTIVE), v_fp: COUNT_W'(VGA_V_FP),
    v_sync:   COUNT_W'(VGA_V_SYNC),   v_bp: COUNT_W'(VGA_V_BP)
  };

  function automatic int mode_h_total(vga_mode_t m);
    return int'(m.h_active) + int'(m.h_fp) + int'(m.h_sync) + int'(m.h_bp);
  endfunction

  function automatic int mode_v_total(vga_mode_t m);
    return int'(m.v_active) + int'(m.v_fp) + int'(m.v_sync) + int'(m.v_bp);
  endfunction

endpackage

// File: rtl/vga_timing_wrap_counter.sv
// Enabled up-counter 0..MAX. wrap is combinational so a downstream counter can
// chain on it within the same cycle.
module wrap_counter #(
  parameter int MAX = 1055,
  parameter int W   = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_reg;

  assign wrap = en && (cnt_reg == MAX_V);
  assign cnt  = cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (wrap) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

endmodule

// File: rtl/vga_timing.sv
// VGA raster source: h/v counters, registered sync/blank decode, frame tick and
// frame counter. Sync/blank are decoded from next-count values to stay aligned.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  output logic [COUNT_W-1:0] hcount,
  output logic [COUNT_W-1:0] vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               frame_tick,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COUNT_W-1:0] HB_START = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] HS_START = COUNT_W'(H_ACTIVE + H_FP);
  localparam logic [COUNT_W-1:0] HS_END   = COUNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [COUNT_W-1:0] VB_START = COUNT_W'(V_ACTIVE);
  localparam logic [COUNT_W-1:0] VS_START = COUNT_W'(V_ACTIVE + V_FP);
  localparam logic [COUNT_W-1:0] VS_END   = COUNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [COUNT_W-1:0] h_cnt, v_cnt;
  logic [COUNT_W-1:0] h_next, v_next;
  logic               h_wrap, v_wrap, v_en;
  logic               hs_on, vs_on;

  logic               hsync_reg, vsync_reg, hblnk_reg, vblnk_reg;
  logic               frame_tick_reg;
  logic [FRAME_W-1:0] frame_cnt_reg;

  assign v_en = pix_en & h_wrap;

  wrap_counter #(.MAX(H_TOTAL - 1), .W(COUNT_W)) u_hcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL - 1), .W(COUNT_W)) u_vcnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v_en),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  // Mirror of what the counters will hold after this edge.
  always_comb begin
    h_next = h_cnt;
    v_next = v_cnt;
    if (h_wrap) begin
      h_next = '0;
    end else if (pix_en) begin
      h_next = h_cnt + COUNT_W'(1);
    end
    if (v_wrap) begin
      v_next = '0;
    end else if (v_en) begin
      v_next = v_cnt + COUNT_W'(1);
    end
  end

  assign hs_on = (h_next >= HS_START) && (h_next <= HS_END);
  assign vs_on = (v_next >= VS_START) && (v_next <= VS_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_reg <= ~SYNC_POL;
      vsync_reg <= ~SYNC_POL;
      hblnk_reg <= 1'b0;
      vblnk_reg <= 1'b0;
    end else if (pix_en) begin
      hsync_reg <= hs_on ? SYNC_POL : ~SYNC_POL;
      vsync_reg <= vs_on ? SYNC_POL : ~SYNC_POL;
      hblnk_reg <= (h_next >= HB_START);
      vblnk_reg <= (v_next >= VB_START);
    end
  end

  // v_wrap already implies pix_en, so the tick drops on disabled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_tick_reg <= 1'b0;
      frame_cnt_reg  <= '0;
    end else begin
      frame_tick_reg <= v_wrap;
      if (v_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + FRAME_W'(1);
      end
    end
  end

  assign hcount     = h_cnt;
  assign vcount     = v_cnt;
  assign hsync      = hsync_reg;
  assign vsync      = vsync_reg;
  assign hblnk      = hblnk_reg;
  assign vblnk      = vblnk_reg;
  assign frame_tick = frame_tick_reg;
  assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: a reduced mode at both sync polarities plus a
// one-pixel mode whose frame counter wraps within a short run.
module tb_vga_timing;
  import vga_pkg::*;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        tick;
    logic [15:0] f;
  } exp_t;
  typedef exp_t [2:0] exp3_t;

  localparam vga_mode_t M_SMALL = '{
    h_active: 11'd8, h_fp: 11'd2, h_sync: 11'd3, h_bp: 11'd2,
    v_active: 11'd4, v_fp: 11'd1, v_sync: 11'd2, v_bp: 11'd1
  };
  localparam vga_mode_t M_TINY = '{
    h_active: 11'd0, h_fp: 11'd0, h_sync: 11'd1, h_bp: 11'd0,
    v_active: 11'd0, v_fp: 11'd0, v_sync: 11'd1, v_bp: 11'd0
  };

  logic clk = 1'b0;
  logic rst_n;
  logic pix_en;

  logic [10:0] hc [3];
  logic [10:0] vc [3];
  logic        hs [3];
  logic        vs [3];
  logic        hb [3];
  logic        vb [3];
  logic        tk [3];
  logic [15:0] fc [3];

  int n_checks = 0;
  int n_errors = 0;

  int          mh [3];
  int          mv [3];
  logic [15:0] mf [3];
  logic        mt [3];
  logic        m_fresh [3];

  exp3_t sb_q [$];

  always #5 clk = ~clk;

  vga_timing #(
    .H_ACTIVE(int'(M_SMALL.h_active)), .H_FP(int'(M_SMALL.h_fp)),
    .H_SYNC(int'(M_SMALL.h_sync)), .H_BP(int'(M_SMALL.h_bp)),
    .V_ACTIVE(int'(M_SMALL.v_active)), .V_FP(int'(M_SMALL.v_fp)),
    .V_SYNC(int'(M_SMALL.v_sync)), .V_BP(int'(M_SMALL.v_bp)),
    .SYNC_POL(1'b1)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(hc[0]), .vcount(vc[0]), .hsync(hs[0]), .vsync(vs[0]),
    .hblnk(hb[0]), .vblnk(vb[0]), .frame_tick(tk[0]), .frame_cnt(fc[0])
  );

  vga_timing #(
    .H_ACTIVE(int'(M_SMALL.h_active)), .H_FP(int'(M_SMALL.h_fp)),
    .H_SYNC(int'(M_SMALL.h_sync)), .H_BP(int'(M_SMALL.h_bp)),
    .V_ACTIVE(int'(M_SMALL.v_active)), .V_FP(int'(M_SMALL.v_fp)),
    .V_SYNC(int'(M_SMALL.v_sync)), .V_BP(int'(M_SMALL.v_bp)),
    .SYNC_POL(1'b0)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(hc[1]), .vcount(vc[1]), .hsync(hs[1]), .vsync(vs[1]),
    .hblnk(hb[1]), .vblnk(vb[1]), .frame_tick(tk[1]), .frame_cnt(fc[1])
  );

  vga_timing #(
    .H_ACTIVE(int'(M_TINY.h_active)), .H_FP(int'(M_TINY.h_fp)),
    .H_SYNC(int'(M_TINY.h_sync)), .H_BP(int'(M_TINY.h_bp)),
    .V_ACTIVE(int'(M_TINY.v_active)), .V_FP(int'(M_TINY.v_fp)),
    .V_SYNC(int'(M_TINY.v_sync)), .V_BP(int'(M_TINY.v_bp)),
    .SYNC_POL(1'b1)
  ) dut_t (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hcount(hc[2]), .vcount(vc[2]), .hsync(hs[2]), .vsync(vs[2]),
    .hblnk(hb[2]), .vblnk(vb[2]), .frame_tick(tk[2]), .frame_cnt(fc[2])
  );

  function automatic vga_mode_t mode_of(int k);
    return (k == 2) ? M_TINY : M_SMALL;
  endfunction

  function automatic logic pol_of(int k);
    return (k != 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mh[k] = 0; mv[k] = 0; mf[k] = 16'h0000; mt[k] = 1'b0; m_fresh[k] = 1'b1;
    end
  endtask

  task automatic model_advance(input logic en);
    for (int k = 0; k < 3; k++) begin
      mt[k] = 1'b0;
      if (en) begin
        m_fresh[k] = 1'b0;
        if (mh[k] == mode_h_total(mode_of(k)) - 1) begin
          mh[k] = 0;
          if (mv[k] == mode_v_total(mode_of(k)) - 1) begin
            mv[k] = 0;
            mf[k] = mf[k] + 16'h0001;
            mt[k] = 1'b1;
          end else begin
            mv[k] = mv[k] + 1;
          end
        end else begin
          mh[k] = mh[k] + 1;
        end
      end
    end
  endtask

  function automatic exp_t predict(int k);
    exp_t      e;
    vga_mode_t m = mode_of(k);
    logic      p = pol_of(k);
    int        hs0 = int'(m.h_active) + int'(m.h_fp);
    int        vs0 = int'(m.v_active) + int'(m.v_fp);
    e.h = 11'(mh[k]);
    e.v = 11'(mv[k]);
    e.f = mf[k];
    e.tick = mt[k];
    if (m_fresh[k]) begin
      e.hs = ~p; e.vs = ~p; e.hb = 1'b0; e.vb = 1'b0;
    end else begin
      e.hs = (mh[k] >= hs0 && mh[k] <= hs0 + int'(m.h_sync) - 1) ? p : ~p;
      e.vs = (mv[k] >= vs0 && mv[k] <= vs0 + int'(m.v_sync) - 1) ? p : ~p;
      e.hb = (mh[k] >= int'(m.h_active));
      e.vb = (mv[k] >= int'(m.v_active));
    end
    return e;
  endfunction

  task automatic push_expected();
    exp3_t x;
    for (int k = 0; k < 3; k++) x[k] = predict(k);
    sb_q.push_back(x);
  endtask

  task automatic compare_pop();
    exp3_t x;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    x = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("d%0d.hcount", k), 32'(hc[k]), 32'(x[k].h));
      check($sformatf("d%0d.vcount", k), 32'(vc[k]), 32'(x[k].v));
      check($sformatf("d%0d.hsync", k), 32'(hs[k]), 32'(x[k].hs));
      check($sformatf("d%0d.vsync", k), 32'(vs[k]), 32'(x[k].vs));
      check($sformatf("d%0d.hblnk", k), 32'(hb[k]), 32'(x[k].hb));
      check($sformatf("d%0d.vblnk", k), 32'(vb[k]), 32'(x[k].vb));
      check($sformatf("d%0d.frame_tick", k), 32'(tk[k]), 32'(x[k].tick));
      check($sformatf("d%0d.frame_cnt", k), 32'(fc[k]), 32'(x[k].f));
    end
  endtask

  // Drive after a negedge, let one posedge pass, compare on the next negedge.
  task automatic cycle(input logic en);
    pix_en = en;
    model_advance(en);
    push_expected();
    @(posedge clk);
    @(negedge clk);
    compare_pop();
  endtask

  initial begin
    logic b;
    rst_n  = 1'b0;
    pix_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    push_expected();
    compare_pop();
    $display("reset: checks=%0d errors=%0d", n_checks, n_errors);

    rst_n = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    repeat (2 * 120 + 3) cycle(1'b1);
    $display("two frames enabled: frame_cnt=%0d errors=%0d", fc[0], n_errors);

    for (int i = 0; i < 150; i++) begin
      b = 1'($urandom_range(0, 1));
      cycle(b);
    end
    $display("random pix_en: h=%0d v=%0d errors=%0d", hc[0], vc[0], n_errors);

    for (int i = 0; i < 300 && !(mh[0] == 13 && mv[0] == 7); i++) cycle(1'b1);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    $display("pix_en hold at last pixel: tick=%0d frame_cnt=%0d errors=%0d", tk[0], fc[0], n_errors);

    for (int i = 0; i < 300 && !(mh[0] == 5 && mv[0] == 3); i++) cycle(1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    push_expected();
    #1;
    compare_pop();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1);
    $display("async reset mid-line: h=%0d v=%0d errors=%0d", hc[0], vc[0], n_errors);

    for (int i = 0; i < 65540; i++) begin
      cycle(1'b1);
      if (mt[2] && mf[2] == 16'h0000)
        $display("tiny mode frame_cnt wrap: frame_cnt=0x%04h tick=%0d", fc[2], tk[2]);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
